cam_seq: RTL and testbench
==========================

# cam_seq

Command sequencer for the 16-entry x 8-bit CAM in the tt_um_top user design. It clears every CAM location after reset and tracks which entries are occupied. It accepts write, search, insert and delete commands over a valid/ready interface, drives the CAM write and search ports, and returns one response per command. This replaces host-driven manual initialisation and free-slot bookkeeping.

## Interface
- ADDR_W, 4: CAM address width; entry count = 2**ADDR_W.
- DATA_W, 8: key/data width.
- CAM_LAT, 1: cycles from cam_srch high to cam_hit/cam_hit_addr valid (range 1..3).
- FILL, 0: value written to free/cleared entries.
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  design enable; gates command acceptance and the init walk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 WRITE, 01 SEARCH, 10 INSERT, 11 DELETE.
- cmd_addr  in  ADDR_W  target address (WRITE only).
- cmd_data  in  DATA_W  data (WRITE/INSERT) or key (SEARCH/DELETE).
- rsp_valid  out  1  single-cycle response pulse; no backpressure.
- rsp_found  out  1  SEARCH/DELETE hit on occupied entry; WRITE/INSERT success.
- rsp_addr  out  ADDR_W  hit address or written address.
- rsp_full  out  1  INSERT rejected, no free entry.
- init_done  out  1  clear walk complete.
- cam_we  out  1  CAM write strobe.
- cam_waddr  out  ADDR_W  CAM write address.
- cam_wdata  out  DATA_W  CAM write data.
- cam_srch  out  1  CAM search strobe.
- cam_key  out  DATA_W  CAM search key.
- cam_hit  in  1  CAM match flag.
- cam_hit_addr  in  ADDR_W  CAM lowest matching address.
- stat_hits, stat_miss  out  8 each  search statistics (see Configuration).

## Operation
- FSM states: INIT, IDLE, EXEC, WAIT, RESP.
- INIT: while ena=1, write FILL to addresses 0..15 in order, one per cycle. ena=0 pauses the walk and holds the address. After address 15, set init_done=1 and go to IDLE.
- Occupancy: 16-bit register, cleared in INIT. WRITE/INSERT set the bit; DELETE clears it.
- IDLE: cmd_ready = ena & init_done. On accept, latch op/addr/data and go to EXEC.
- WRITE: EXEC drives cam_we=1, cam_waddr=cmd_addr, cam_wdata=cmd_data. Response: rsp_found=1, rsp_addr=cmd_addr.
- INSERT: target = lowest clear occupancy bit, priority-encoded at accept. If none: no write; rsp_full=1, rsp_found=0, rsp_addr=0. Otherwise write as for WRITE at the target address.
- SEARCH/DELETE: EXEC drives cam_srch=1, cam_key=data. WAIT counts CAM_LAT cycles, then samples the hit.
  - found = cam_hit & occupancy[cam_hit_addr].
  - A hit on a free FILL entry reports found=0.
  - DELETE with found: RESP drives cam_we=1, cam_waddr=hit address, cam_wdata=FILL, and clears the occupancy bit.
  - On miss, rsp_addr=0.
- All CAM strobes are single-cycle, registered outputs.
- ena low after accept: the in-flight command completes and only new acceptance is blocked.

## Timing
- Reset values: cmd_ready=0, rsp_valid=0, rsp_found=0, rsp_addr=0, rsp_full=0, init_done=0, cam_we=0, cam_waddr=0, cam_wdata=FILL, cam_srch=0, cam_key=0, stats=0.
- Init: first cam_we in the first cycle after rst_n=1 with ena=1. init_done rises 16 enabled cycles later.
- Accept at cycle N:
  - WRITE/INSERT: cam_we at N+1, rsp_valid at N+1, cmd_ready back at N+2.
  - SEARCH: cam_srch at N+1, hit sampled at N+1+CAM_LAT, rsp_valid at N+2+CAM_LAT.
  - DELETE: same as SEARCH, plus cam_we in the rsp_valid cycle.
- Throughput: one command in flight. cmd_ready=0 from the cycle after accept until the cycle after rsp_valid.
- rst_n low mid-command: the command is dropped, with no response. All state returns to reset values and INIT restarts.
- WRITE to an address whose data duplicates another entry: allowed. Search returns the lowest occupied address reported by the CAM.

## Configuration
- CAM_SEQ_STATS_EN defined:
  - stat_hits counts SEARCH responses with found=1.
  - stat_miss counts SEARCH responses with found=0.
  - Both are 8-bit, saturate at 255, and clear on reset.
- Undefined: stat_hits and stat_miss are tied to 0 and no counter logic is synthesised.

## Test plan
- Reset, ena=1 -> 16 cam_we pulses at addresses 0..15 with data 0x00; init_done=1 on the 17th cycle; cmd_ready=1.
- WRITE 0x55@0, 0xAA@1, 0x77@2, 0x33@15; SEARCH 0x55/0xAA/0x77/0x33 -> found=1 with addr 0/1/2/15; SEARCH 0xFF -> found=0.
- SEARCH 0x00 after init (CAM model hits addr 3, which is free) -> found=0; stat_miss increments (with CAM_SEQ_STATS_EN).
- INSERT 16 distinct keys into an empty CAM -> addresses 0..15; 17th INSERT -> rsp_full=1 with no cam_we. DELETE key at addr 1, then INSERT -> addr 1.
- DELETE 0xAA -> found=1, addr 1, and cam_we writes 0x00 at 1; next SEARCH 0xAA -> found=0.
- Assert rst_n=0 during the SEARCH WAIT state with CAM_LAT=3 -> no rsp_valid, init_done=0, and a fresh 16-cycle init walk follows.

Source files
------------

// File: rtl/cam_seq.sv
// cam_seq: command sequencer for a 2**ADDR_W x DATA_W CAM; clears it after reset,
// tracks occupancy, runs WRITE/SEARCH/INSERT/DELETE. Optional search stats: CAM_SEQ_STATS_EN.
module cam_seq #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CAM_LAT = 1,
  parameter logic [DATA_W-1:0] FILL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_found,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_full,
  output logic              init_done,
  output logic              cam_we,
  output logic [ADDR_W-1:0] cam_waddr,
  output logic [DATA_W-1:0] cam_wdata,
  output logic              cam_srch,
  output logic [DATA_W-1:0] cam_key,
  input  logic              cam_hit,
  input  logic [ADDR_W-1:0] cam_hit_addr,
  output logic [7:0]        stat_hits,
  output logic [7:0]        stat_miss,
  output logic [2:0]        dbg_state
);

  // Handshake: a command transfers on a rising edge with cmd_valid & cmd_ready; cmd_ready
  // never depends on cmd_valid. rsp_valid is a one-cycle pulse with no backpressure.
  localparam int ENTRIES = 1 << ADDR_W;
  localparam logic [2:0] S_INIT = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;
  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_SEARCH = 2'b01;
  localparam logic [1:0] OP_INSERT = 2'b10;
  localparam logic [1:0] OP_DELETE = 2'b11;
  localparam logic [1:0] WAIT_LAST = 2'(CAM_LAT - 1);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W:0]    init_cnt_q, init_cnt_d;
  logic [ENTRIES-1:0] occ_q, occ_d;
  logic               init_done_q, init_done_d;
  logic [1:0]         op_q, op_d;
  logic [1:0]         wait_cnt_q, wait_cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_found_q, rsp_found_d;
  logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
  logic               rsp_full_q, rsp_full_d;
  logic               cam_we_q, cam_we_d;
  logic [ADDR_W-1:0]  cam_waddr_q, cam_waddr_d;
  logic [DATA_W-1:0]  cam_wdata_q, cam_wdata_d;
  logic               cam_srch_q, cam_srch_d;
  logic [DATA_W-1:0]  cam_key_q, cam_key_d;

  logic               free_ok;
  logic [ADDR_W-1:0]  free_addr;
  logic               hit_found;
  logic               accept;
  logic               sample;

  always_comb begin
    free_ok   = 1'b0;
    free_addr = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        free_ok   = 1'b1;
        free_addr = ADDR_W'(i);
      end
    end
  end

  // A CAM hit on a cleared (FILL) slot is not a real entry.
  assign hit_found = cam_hit & occ_q[cam_hit_addr];
  assign cmd_ready = ena & init_done_q & (state_q == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign sample    = (state_q == S_WAIT) && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    occ_d       = occ_q;
    init_done_d = init_done_q;
    op_d        = op_q;
    wait_cnt_d  = wait_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_found_d = rsp_found_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_full_d  = rsp_full_q;
    cam_we_d    = 1'b0;
    cam_waddr_d = cam_waddr_q;
    cam_wdata_d = cam_wdata_q;
    cam_srch_d  = 1'b0;
    cam_key_d   = cam_key_q;
    case (state_q)
      S_INIT: begin
        occ_d = '0;
        if (ena) begin
          if (init_cnt_q[ADDR_W]) begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            cam_we_d    = 1'b1;
            cam_waddr_d = init_cnt_q[ADDR_W-1:0];
            cam_wdata_d = FILL;
            init_cnt_d  = init_cnt_q + (ADDR_W+1)'(1);
          end
        end
      end
      S_IDLE: begin
        if (accept) begin
          op_d    = cmd_op;
          state_d = S_EXEC;
          case (cmd_op)
            OP_WRITE: begin
              cam_we_d        = 1'b1;
              cam_waddr_d     = cmd_addr;
              cam_wdata_d     = cmd_data;
              occ_d[cmd_addr] = 1'b1;
              rsp_valid_d     = 1'b1;
              rsp_found_d     = 1'b1;
              rsp_addr_d      = cmd_addr;
              rsp_full_d      = 1'b0;
            end
            OP_INSERT: begin
              rsp_valid_d = 1'b1;
              if (free_ok) begin
                cam_we_d         = 1'b1;
                cam_waddr_d      = free_addr;
                cam_wdata_d      = cmd_data;
                occ_d[free_addr] = 1'b1;
                rsp_found_d      = 1'b1;
                rsp_addr_d       = free_addr;
                rsp_full_d       = 1'b0;
              end else begin
                rsp_found_d = 1'b0;
                rsp_addr_d  = '0;
                rsp_full_d  = 1'b1;
              end
            end
            default: begin
              cam_srch_d = 1'b1;
              cam_key_d  = cmd_data;
            end
          endcase
        end
      end
      S_EXEC: begin
        wait_cnt_d = '0;
        state_d    = op_q[0] ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (sample) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_found_d = hit_found;
          rsp_addr_d  = hit_found ? cam_hit_addr : '0;
          rsp_full_d  = 1'b0;
          if ((op_q == OP_DELETE) && hit_found) begin
            cam_we_d            = 1'b1;
            cam_waddr_d         = cam_hit_addr;
            cam_wdata_d         = FILL;
            occ_d[cam_hit_addr] = 1'b0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      occ_q       <= '0;
      init_done_q <= 1'b0;
      op_q        <= OP_WRITE;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_found_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_full_q  <= 1'b0;
      cam_we_q    <= 1'b0;
      cam_waddr_q <= '0;
      cam_wdata_q <= FILL;
      cam_srch_q  <= 1'b0;
      cam_key_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      occ_q       <= occ_d;
      init_done_q <= init_done_d;
      op_q        <= op_d;
      wait_cnt_q  <= wait_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_found_q <= rsp_found_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_full_q  <= rsp_full_d;
      cam_we_q    <= cam_we_d;
      cam_waddr_q <= cam_waddr_d;
      cam_wdata_q <= cam_wdata_d;
      cam_srch_q  <= cam_srch_d;
      cam_key_q   <= cam_key_d;
    end
  end

`ifdef CAM_SEQ_STATS_EN
  logic [7:0] stat_hits_q, stat_hits_d;
  logic [7:0] stat_miss_q, stat_miss_d;

  always_comb begin
    stat_hits_d = stat_hits_q;
    stat_miss_d = stat_miss_q;
    if (sample && (op_q == OP_SEARCH)) begin
      if (hit_found) begin
        if (stat_hits_q != 8'hFF) stat_hits_d = stat_hits_q + 8'd1;
      end else begin
        if (stat_miss_q != 8'hFF) stat_miss_d = stat_miss_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_hits_q <= '0;
      stat_miss_q <= '0;
    end else begin
      stat_hits_q <= stat_hits_d;
      stat_miss_q <= stat_miss_d;
    end
  end

  assign stat_hits = stat_hits_q;
  assign stat_miss = stat_miss_q;
`else
  assign stat_hits = '0;
  assign stat_miss = '0;
`endif

  assign rsp_valid = rsp_valid_q;
  assign rsp_found = rsp_found_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_full  = rsp_full_q;
  assign init_done = init_done_q;
  assign cam_we    = cam_we_q;
  assign cam_waddr = cam_waddr_q;
  assign cam_wdata = cam_wdata_q;
  assign cam_srch  = cam_srch_q;
  assign cam_key   = cam_key_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cam_seq.sv
// tb_cam_seq: drives cam_seq against a behavioural CAM (lowest-match, CAM_LAT pipeline)
// and a high-level occupancy/contents model.
module tb_cam_seq;
  localparam int LAT = 3;
  localparam logic [7:0] FILL = 8'h00;
  localparam logic [1:0] OP_W = 2'd0, OP_S = 2'd1, OP_I = 2'd2, OP_D = 2'd3;
  localparam int RW = 19;

  logic       clk = 1'b0;
  logic       rst_n, ena, cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_addr;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_found, rsp_full, init_done;
  logic [3:0] rsp_addr;
  logic       cam_we, cam_srch, cam_hit;
  logic [3:0] cam_waddr, cam_hit_addr;
  logic [7:0] cam_wdata, cam_key, stat_hits, stat_miss;
  logic [2:0] dbg_state, st_rst;

  cam_seq #(.ADDR_W(4), .DATA_W(8), .CAM_LAT(LAT), .FILL(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_found(rsp_found), .rsp_addr(rsp_addr), .rsp_full(rsp_full), .init_done(init_done),
    .cam_we(cam_we), .cam_waddr(cam_waddr), .cam_wdata(cam_wdata), .cam_srch(cam_srch),
    .cam_key(cam_key), .cam_hit(cam_hit), .cam_hit_addr(cam_hit_addr),
    .stat_hits(stat_hits), .stat_miss(stat_miss), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // External CAM: returns the lowest matching address LAT cycles after cam_srch.
  logic [7:0] cam_mem [16];
  logic       ph [LAT];
  logic [3:0] pa [LAT];
  logic       m_hit;
  logic [3:0] m_addr;

  always_comb begin
    m_hit  = 1'b0;
    m_addr = '0;
    for (int i = 15; i >= 0; i--) begin
      if (cam_mem[i] == cam_key) begin
        m_hit  = 1'b1;
        m_addr = 4'(i);
      end
    end
  end

  always @(posedge clk) begin
    if (cam_we) cam_mem[cam_waddr] <= cam_wdata;
    ph[0] <= cam_srch & m_hit;
    pa[0] <= m_addr;
    for (int i = 1; i < LAT; i++) begin
      ph[i] <= ph[i-1];
      pa[i] <= pa[i-1];
    end
  end

  assign cam_hit      = ph[LAT-1];
  assign cam_hit_addr = pa[LAT-1];

  int total = 0;
  int bad = 0;
  logic [RW-1:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] pk(input logic we, input logic found, input logic full,
                                       input logic [3:0] ra, input logic [3:0] wa,
                                       input logic [7:0] wd);
    return {we, found, full, ra, wa, wd};
  endfunction

  // Reference model: what the CAM holds, which slots are owned, search statistics.
  logic [7:0] m_cont [16];
  bit         m_occ [16];
  int         m_hits, m_miss;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cont[i] = FILL;
      m_occ[i]  = 1'b0;
    end
    m_hits = 0;
    m_miss = 0;
  endtask

  function automatic logic [RW-1:0] model_apply(input logic [1:0] op, input logic [3:0] addr,
                                                input logic [7:0] data);
    int idx;
    bit found;
    logic [RW-1:0] r;
    r = pk(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'h00);
    if (op == OP_W) begin
      m_cont[addr] = data;
      m_occ[addr]  = 1'b1;
      r = pk(1'b1, 1'b1, 1'b0, addr, addr, data);
    end else if (op == OP_I) begin
      idx = -1;
      for (int i = 15; i >= 0; i--) if (!m_occ[i]) idx = i;
      if (idx >= 0) begin
        m_cont[idx] = data;
        m_occ[idx]  = 1'b1;
        r = pk(1'b1, 1'b1, 1'b0, 4'(idx), 4'(idx), data);
      end
    end else begin
      idx = -1;
      for (int i = 15; i >= 0; i--) if (m_cont[i] == data) idx = i;
      found = 1'b0;
      if (idx >= 0) found = m_occ[idx];
      if (op == OP_S) begin
        if (found) begin
          if (m_hits < 255) m_hits++;
        end else if (m_miss < 255) m_miss++;
      end
      if (op == OP_D && found) begin
        m_cont[idx] = FILL;
        m_occ[idx]  = 1'b0;
        r = pk(1'b1, 1'b1, 1'b0, 4'(idx), 4'(idx), FILL);
      end else begin
        r = pk(1'b0, found, 1'b0, found ? 4'(idx) : 4'h0, 4'h0, 8'h00);
      end
    end
    return r;
  endfunction

  task automatic do_cmd(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] data,
                        input logic [RW-1:0] exp, input bit drop_ena);
    int k;
    logic [RW-1:0] act, e;
    exp_q.push_back(exp);
    k = 0;
    while (!cmd_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) begin
      check("ready_timeout", cmd_ready, 1);
      e = exp_q.pop_front();
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (drop_ena) ena = 1'b0;
    check("busy_ready", cmd_ready, 0);
    if (op[0]) check("srch_strobe", {cam_srch, cam_key}, {1'b1, data});
    k = 1;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    e = exp_q.pop_front();
    if (!rsp_valid) begin
      check("rsp_timeout", rsp_valid, 1);
      ena = 1'b1;
      return;
    end
    check("rsp_latency", k, op[0] ? 2 + LAT : 1);
    act = pk(cam_we, rsp_found, rsp_full, rsp_addr, cam_we ? cam_waddr : 4'h0,
             cam_we ? cam_wdata : 8'h00);
    check("rsp", act, e);
    @(negedge clk);
    check("rsp_pulse_ready", {rsp_valid, cmd_ready}, {1'b0, ena});
    ena = 1'b1;
  endtask

  task automatic check_walk(input int pause_at);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("walk", {cam_we, cam_waddr, cam_wdata, init_done}, {1'b1, 4'(i), FILL, 1'b0});
      if (i == pause_at) begin
        ena = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("walk_pause", {cam_we, init_done}, 0);
        end
        ena = 1'b1;
      end
    end
    @(negedge clk);
    check("init_done", {init_done, cmd_ready, cam_we}, 3'b110);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_stats();
`ifdef CAM_SEQ_STATS_EN
    check("stat_hits", stat_hits, m_hits);
    check("stat_miss", stat_miss, m_miss);
`else
    check("stat_tied", {stat_hits, stat_miss}, 0);
`endif
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] data;
    logic       found;
    logic       full;
    logic [3:0] raddr;
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] op, input logic [3:0] addr,
                               input logic [7:0] data, input logic found, input logic full,
                               input logic [3:0] raddr);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.found = found; v.full = full; v.raddr = raddr;
    return v;
  endfunction

  vec_t          tbl [17];
  logic [7:0]    keys [8];
  logic [RW-1:0] e;
  logic          we;
  logic [1:0]    rop;
  logic [3:0]    ra;
  logic [7:0]    rd;
  int            n;

  initial begin
    tbl[0]  = mkv(OP_W, 4'd0,  8'h55, 1, 0, 4'd0);
    tbl[1]  = mkv(OP_W, 4'd1,  8'hAA, 1, 0, 4'd1);
    tbl[2]  = mkv(OP_W, 4'd2,  8'h77, 1, 0, 4'd2);
    tbl[3]  = mkv(OP_W, 4'd15, 8'h33, 1, 0, 4'd15);
    tbl[4]  = mkv(OP_S, 4'd0,  8'h55, 1, 0, 4'd0);
    tbl[5]  = mkv(OP_S, 4'd0,  8'hAA, 1, 0, 4'd1);
    tbl[6]  = mkv(OP_S, 4'd0,  8'h77, 1, 0, 4'd2);
    tbl[7]  = mkv(OP_S, 4'd0,  8'h33, 1, 0, 4'd15);
    tbl[8]  = mkv(OP_S, 4'd0,  8'hFF, 0, 0, 4'd0);
    tbl[9]  = mkv(OP_S, 4'd0,  8'h00, 0, 0, 4'd0);
    tbl[10] = mkv(OP_D, 4'd0,  8'hAA, 1, 0, 4'd1);
    tbl[11] = mkv(OP_S, 4'd0,  8'hAA, 0, 0, 4'd0);
    tbl[12] = mkv(OP_W, 4'd5,  8'h77, 1, 0, 4'd5);
    tbl[13] = mkv(OP_S, 4'd0,  8'h77, 1, 0, 4'd2);
    tbl[14] = mkv(OP_D, 4'd0,  8'h77, 1, 0, 4'd2);
    tbl[15] = mkv(OP_S, 4'd0,  8'h77, 1, 0, 4'd5);
    tbl[16] = mkv(OP_I, 4'd0,  8'h99, 1, 0, 4'd1);
    keys = '{8'h00, 8'h20, 8'h21, 8'h22, 8'h41, 8'h50, 8'h51, 8'h52};

    rst_n = 1'b0; ena = 1'b1; cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_addr = 4'd0; cmd_data = 8'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_flags", {cmd_ready, rsp_valid, rsp_found, rsp_full, init_done, cam_we, cam_srch}, 0);
    check("rst_addr", {rsp_addr, cam_waddr}, 0);
    check("rst_data", {cam_wdata, cam_key}, {FILL, 8'h00});
    check("rst_stats", {stat_hits, stat_miss}, 0);
    st_rst = dbg_state;
    rst_n = 1'b1;
    check_walk(-1);
    check("state_moves", dbg_state != st_rst, 1);

    for (int i = 0; i < 17; i++) begin
      we = (tbl[i].op == OP_W) || (tbl[i].op == OP_I && !tbl[i].full) ||
           (tbl[i].op == OP_D && tbl[i].found);
      e = pk(we, tbl[i].found, tbl[i].full, tbl[i].raddr, we ? tbl[i].raddr : 4'h0,
             we ? ((tbl[i].op == OP_D) ? FILL : tbl[i].data) : 8'h00);
      void'(model_apply(tbl[i].op, tbl[i].addr, tbl[i].data));
      do_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, e, 1'b0);
    end
    check_stats();

    // Fill an empty CAM with INSERTs, overflow, then reuse a deleted slot.
    do_reset();
    check_walk(6);
    for (int i = 0; i < 16; i++) begin
      void'(model_apply(OP_I, 4'd0, 8'h20 + 8'(i)));
      do_cmd(OP_I, 4'd0, 8'h20 + 8'(i), pk(1'b1, 1'b1, 1'b0, 4'(i), 4'(i), 8'h20 + 8'(i)), 1'b0);
    end
    void'(model_apply(OP_I, 4'd0, 8'h40));
    do_cmd(OP_I, 4'd0, 8'h40, pk(1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 8'h00), 1'b0);
    void'(model_apply(OP_D, 4'd0, 8'h21));
    do_cmd(OP_D, 4'd0, 8'h21, pk(1'b1, 1'b1, 1'b0, 4'd1, 4'd1, FILL), 1'b0);
    void'(model_apply(OP_I, 4'd0, 8'h41));
    do_cmd(OP_I, 4'd0, 8'h41, pk(1'b1, 1'b1, 1'b0, 4'd1, 4'd1, 8'h41), 1'b1);

    for (int i = 0; i < 250; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = 4'($urandom_range(0, 15));
      rd  = keys[$urandom_range(0, 7)];
      e   = model_apply(rop, ra, rd);
      do_cmd(rop, ra, rd, e, $urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    check_stats();

    // Reset while a SEARCH sits in WAIT: no response, init walk restarts.
    n = 0;
    while (!cmd_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("mid_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = OP_S; cmd_data = 8'h20;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_mid", {rsp_valid, init_done, cmd_ready, cam_we, cam_srch}, 0);
    end
    rst_n = 1'b1;
    model_reset();
    check_walk(10);
    e = model_apply(OP_S, 4'd0, 8'h20);
    do_cmd(OP_S, 4'd0, 8'h20, e, 1'b0);
    e = model_apply(OP_W, 4'd7, 8'h20);
    do_cmd(OP_W, 4'd7, 8'h20, e, 1'b0);
    e = model_apply(OP_S, 4'd0, 8'h20);
    do_cmd(OP_S, 4'd0, 8'h20, e, 1'b0);
    e = model_apply(OP_S, 4'd0, 8'h00);
    do_cmd(OP_S, 4'd0, 8'h00, e, 1'b0);
    check_stats();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
